// File: rtl/phy_tx_8b10b_framer_if.sv
// phy_tx_8b10b_framer_if: AXI-Stream source beats in, GT TX data/char-K words out.
interface phy_tx_8b10b_framer_if;
  logic [31:0] i_tx_axis_data;
  logic [3:0]  i_tx_axis_keep;
  logic        i_tx_axis_valid;
  logic        i_tx_axis_last;
  logic        o_tx_axis_ready;
  logic [31:0] o_gt_tx_data;
  logic [3:0]  o_gt_tx_char;
  modport master (
    output i_tx_axis_data, i_tx_axis_keep, i_tx_axis_valid, i_tx_axis_last,
    input  o_tx_axis_ready, o_gt_tx_data, o_gt_tx_char
  );
  modport slave (
    input  i_tx_axis_data, i_tx_axis_keep, i_tx_axis_valid, i_tx_axis_last,
    output o_tx_axis_ready, o_gt_tx_data, o_gt_tx_char
  );
endinterface

// File: rtl/phy_tx_8b10b_framer.sv
// phy_tx_8b10b_framer: wraps AXI-Stream frames as SOF/payload/EOF between K28.5 idle words.
// Define PHY_TX_STAT_EN to add saturating frame and underrun counters.
module phy_tx_8b10b_framer #(
  parameter int unsigned IFG_WORDS = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_link_up,
  phy_tx_8b10b_framer_if.slave tx,
  output logic o_tx_underrun
`ifdef PHY_TX_STAT_EN
  ,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_underrun_cnt
`endif
);
  localparam logic [31:0] IDLE_W   = 32'hBC50BC50;
  localparam logic [3:0]  IDLE_K   = 4'b1010;
  localparam logic [31:0] SOF_W    = 32'hBCBC50FB;
  localparam logic [3:0]  SOF_K    = 4'b1101;
  localparam logic [31:0] EOF_W    = 32'hFDBCBCBC;
  localparam logic [3:0]  EOF_K    = 4'b1111;
  localparam logic [3:0]  GAP_INIT = 4'(IFG_WORDS);
  typedef enum logic [2:0] {S_IDLE, S_SOF, S_DATA, S_EOF, S_GAP} state_t;
  state_t      state_q, state_d;
  logic [31:0] w_q, w_d;
  logic [3:0]  k_q, k_d, gap_q, gap_d;
  logic        ready_q, ready_d, uf_q, uf_d, part;
  logic [31:0] d;
  logic [3:0]  kp;
  assign d    = tx.i_tx_axis_data;
  assign kp   = tx.i_tx_axis_keep;
  assign part = tx.i_tx_axis_last && (kp inside {4'b1110, 4'b1100, 4'b1000});
  always_comb begin
    state_d = state_q;
    w_d     = IDLE_W;
    k_d     = IDLE_K;
    gap_d   = (gap_q != '0) ? gap_q - 4'd1 : '0;
    uf_d    = 1'b0;
    case (state_q)
      S_IDLE:
        if (i_link_up && tx.i_tx_axis_valid && gap_q == '0) begin
          state_d = S_SOF;
          w_d     = SOF_W;
          k_d     = SOF_K;
        end
      S_SOF, S_DATA:
        if (!i_link_up || (state_q == S_DATA && !tx.i_tx_axis_valid)) begin
          state_d = S_GAP;
          w_d     = EOF_W;
          k_d     = EOF_K;
          gap_d   = GAP_INIT;
          uf_d    = 1'b1;
        end else if (tx.i_tx_axis_valid) begin
          state_d = S_DATA;
          w_d     = d;
          k_d     = 4'b0000;
          // Short last beat carries its own EOF in the first unused byte lane.
          if (part) begin
            state_d = S_GAP;
            gap_d   = GAP_INIT;
            w_d     = kp[1] ? {d[31:8], 8'hFD} : kp[2] ? {d[31:16], 16'hFDBC} : {d[31:24], 24'hFDBCBC};
            k_d     = kp[1] ? 4'b0001 : kp[2] ? 4'b0011 : 4'b0111;
          end else if (tx.i_tx_axis_last) begin
            state_d = S_EOF;
            w_d     = (kp == 4'b1111) ? d : IDLE_W;
            k_d     = (kp == 4'b1111) ? 4'b0000 : IDLE_K;
          end
        end
      S_EOF: begin
        state_d = S_GAP;
        w_d     = EOF_W;
        k_d     = EOF_K;
        gap_d   = GAP_INIT;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_SOF) || (state_d == S_DATA);
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= S_IDLE;
      w_q     <= IDLE_W;
      k_q     <= IDLE_K;
      gap_q   <= GAP_INIT;
      ready_q <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
      uf_q    <= uf_d;
    end
  assign tx.o_gt_tx_data    = {w_q[7:0], w_q[15:8], w_q[23:16], w_q[31:24]};
  assign tx.o_gt_tx_char    = {k_q[0], k_q[1], k_q[2], k_q[3]};
  assign tx.o_tx_axis_ready = ready_q;
  assign o_tx_underrun      = uf_q;
`ifdef PHY_TX_STAT_EN
  logic        frame_done;
  logic [15:0] frame_cnt_q, frame_cnt_d, underrun_cnt_q, underrun_cnt_d;
  // Counts land on the same edge the terminating word reaches the GT.
  assign frame_done = state_q == S_EOF ||
                      ((state_q == S_SOF || state_q == S_DATA) && i_link_up && tx.i_tx_axis_valid && part);
  always_comb begin
    frame_cnt_d    = (frame_done && ~&frame_cnt_q) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    underrun_cnt_d = (uf_d && ~&underrun_cnt_q) ? underrun_cnt_q + 16'd1 : underrun_cnt_q;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
    end else begin
      frame_cnt_q    <= frame_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  assign o_frame_cnt    = frame_cnt_q;
  assign o_underrun_cnt = underrun_cnt_q;
`endif
endmodule

// File: tb/tb_phy_tx_8b10b_framer.sv
// tb_phy_tx_8b10b_framer: cycle vector table, corner-case sequences and a random frame stream vs a word-level model.
module tb_phy_tx_8b10b_framer;
  localparam int IFG = 2;
  localparam logic [31:0] IDLE_W = 32'hBC50BC50;
  localparam logic [3:0]  IDLE_K = 4'b1010;
  localparam logic [31:0] SOF_W  = 32'hBCBC50FB;
  localparam logic [3:0]  SOF_K  = 4'b1101;
  localparam logic [31:0] EOF_W  = 32'hFDBCBCBC;
  localparam logic [3:0]  EOF_K  = 4'b1111;
  typedef struct {
    logic v; logic [31:0] d; logic l; logic [3:0] kp;
    logic [31:0] ew; logic [3:0] ek; logic er;
  } vec_t;
  logic clk = 1'b0, rst, link_up, uf;
  logic [31:0] w_int;
  logic [3:0]  k_int;
  int n_vec = 0, n_err = 0, idle_run = 0;
  bit mon_on = 1'b0;
  logic [35:0] exp_q[$];
  vec_t tbl[$];
`ifdef PHY_TX_STAT_EN
  logic [15:0] frame_cnt, underrun_cnt;
`endif
  phy_tx_8b10b_framer_if tx_if();
  phy_tx_8b10b_framer #(.IFG_WORDS(IFG)) dut (
    .i_clk(clk), .i_rst(rst), .i_link_up(link_up), .tx(tx_if), .o_tx_underrun(uf)
`ifdef PHY_TX_STAT_EN
    , .o_frame_cnt(frame_cnt), .o_underrun_cnt(underrun_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rev32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction
  function automatic logic [3:0] rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction
  assign w_int = rev32(tx_if.o_gt_tx_data);
  assign k_int = rev4(tx_if.o_gt_tx_char);
  function automatic logic [63:0] obs();
    return {26'd0, w_int, k_int, tx_if.o_tx_axis_ready, uf};
  endfunction
  function automatic logic [63:0] ex(input logic [31:0] w, input logic [3:0] k, input logic r, input logic u);
    return {26'd0, w, k, r, u};
  endfunction
  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic l, input logic [3:0] kp,
                              input logic [31:0] ew, input logic [3:0] ek, input logic er);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.kp = kp; t.ew = ew; t.ek = ek; t.er = er;
    return t;
  endfunction
  // Terminating word(s) of a frame: kept bytes, then FD, then BC fill; a full beat gets a separate EOF word.
  function automatic void push_term(input logic [31:0] d, input logic [3:0] kp);
    int n;
    logic [31:0] w;
    logic [3:0] k;
    n = $countones(kp);
    for (int i = 0; i < 4; i++) begin
      w[31 - 8*i -: 8] = (i < n) ? d[31 - 8*i -: 8] : (i == n) ? 8'hFD : 8'hBC;
      k[3 - i] = (i >= n);
    end
    exp_q.push_back({w, k});
    if (n == 4) exp_q.push_back({EOF_W, EOF_K});
  endfunction
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic [3:0] kp);
    tx_if.i_tx_axis_valid = v;
    tx_if.i_tx_axis_data  = d;
    tx_if.i_tx_axis_last  = l;
    tx_if.i_tx_axis_keep  = kp;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_beat(input logic [31:0] d, input logic l, input logic [3:0] kp, output bit ok);
    bit hs;
    hs = 1'b0;
    drive(1'b1, d, l, kp);
    for (int t = 0; t < 200 && !hs; t++) begin
      @(negedge clk);
      hs = tx_if.o_tx_axis_ready;
      step();
    end
    ok = hs;
  endtask
  always @(negedge clk)
    if (mon_on) begin
      if (w_int == IDLE_W && k_int == IDLE_K) idle_run++;
      else begin
        if (w_int == SOF_W && k_int == SOF_K) check("rand_ifg", 64'(idle_run >= IFG), 64'd1);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rand_stray: got %h/%b expected no word", w_int, k_int);
        end else check("rand_word", {28'd0, w_int, k_int}, {28'd0, exp_q.pop_front()});
        if (k_int != 4'b0000 && !(w_int == SOF_W && k_int == SOF_K)) idle_run = 0;
      end
      check("rand_uf", 64'(uf), 64'd0);
    end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    bit ok;
    int len, dly;
    logic [3:0] kp;
    logic [31:0] dd[5];
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 4'hF, IDLE_W,       IDLE_K,  1'b0));
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 4'hF, IDLE_W,       IDLE_K,  1'b0));
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 4'hF, IDLE_W,       IDLE_K,  1'b0));
    tbl.push_back(mk(1'b1, 32'h11223344, 1'b0, 4'hF, SOF_W,        SOF_K,   1'b1));
    tbl.push_back(mk(1'b1, 32'h11223344, 1'b0, 4'hF, 32'h11223344, 4'b0000, 1'b1));
    tbl.push_back(mk(1'b1, 32'h55667788, 1'b0, 4'hF, 32'h55667788, 4'b0000, 1'b1));
    tbl.push_back(mk(1'b1, 32'h99AABBCC, 1'b1, 4'hF, 32'h99AABBCC, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 4'hF, EOF_W,        EOF_K,   1'b0));
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 4'hF, IDLE_W,       IDLE_K,  1'b0));
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 4'hF, IDLE_W,       IDLE_K,  1'b0));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 4'hE, SOF_W,        SOF_K,   1'b1));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 4'hE, 32'hDEADBEFD, 4'b0001, 1'b0));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 4'hC, IDLE_W,       IDLE_K,  1'b0));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 4'hC, IDLE_W,       IDLE_K,  1'b0));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 4'hC, SOF_W,        SOF_K,   1'b1));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 4'hC, 32'hDEADFDBC, 4'b0011, 1'b0));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 4'h8, IDLE_W,       IDLE_K,  1'b0));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 4'h8, IDLE_W,       IDLE_K,  1'b0));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 4'h8, SOF_W,        SOF_K,   1'b1));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 4'h8, 32'hDEFDBCBC, 4'b0111, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 4'hF, IDLE_W,       IDLE_K,  1'b0));
    rst = 1'b1;
    link_up = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 4'hF);
    repeat (2) step();
    check("reset_word", obs(), ex(IDLE_W, IDLE_K, 1'b0, 1'b0));
    check("reset_gt_pins", {28'd0, tx_if.o_gt_tx_data, tx_if.o_gt_tx_char}, {28'd0, 32'h50BC50BC, 4'b0101});
    rst = 1'b0;
    drive(1'b1, 32'hCAFEF00D, 1'b1, 4'hF);
    for (int i = 0; i < 4; i++) begin
      step();
      check("link_down_idle", obs(), ex(IDLE_W, IDLE_K, 1'b0, 1'b0));
    end
    link_up = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].kp);
      step();
      check($sformatf("vec%0d", i), obs(), ex(tbl[i].ew, tbl[i].ek, tbl[i].er, 1'b0));
    end
`ifdef PHY_TX_STAT_EN
    check("frame_cnt_table", 64'(frame_cnt), 64'd4);
`endif
    send_beat(32'hA0000001, 1'b0, 4'hF, ok);
    check("ur_beat1", obs(), ex(32'hA0000001, 4'b0000, 1'b1, 1'b0));
    send_beat(32'hA0000002, 1'b0, 4'hF, ok);
    check("ur_beat2", obs(), ex(32'hA0000002, 4'b0000, 1'b1, 1'b0));
    drive(1'b0, 32'h0, 1'b0, 4'hF);
    step();
    check("ur_eof", obs(), ex(EOF_W, EOF_K, 1'b0, 1'b1));
    step();
    check("ur_end", obs(), ex(IDLE_W, IDLE_K, 1'b0, 1'b0));
`ifdef PHY_TX_STAT_EN
    check("ur_underrun_cnt", 64'(underrun_cnt), 64'd1);
    check("ur_frame_cnt", 64'(frame_cnt), 64'd4);
`endif
    send_beat(32'hB0000001, 1'b0, 4'hF, ok);
    send_beat(32'hB0000002, 1'b0, 4'hF, ok);
    check("ld_beat2", obs(), ex(32'hB0000002, 4'b0000, 1'b1, 1'b0));
    link_up = 1'b0;
    drive(1'b1, 32'hB0000003, 1'b0, 4'hF);
    step();
    check("ld_eof", obs(), ex(EOF_W, EOF_K, 1'b0, 1'b1));
    drive(1'b0, 32'h0, 1'b0, 4'hF);
    step();
    check("ld_end", obs(), ex(IDLE_W, IDLE_K, 1'b0, 1'b0));
    link_up = 1'b1;
`ifdef PHY_TX_STAT_EN
    check("ld_underrun_cnt", 64'(underrun_cnt), 64'd2);
`endif
    send_beat(32'hC0000001, 1'b0, 4'hF, ok);
    check("rs_beat1", obs(), ex(32'hC0000001, 4'b0000, 1'b1, 1'b0));
    drive(1'b1, 32'hC0000002, 1'b0, 4'hF);
    #2 rst = 1'b1;
    #1 check("rs_async", obs(), ex(IDLE_W, IDLE_K, 1'b0, 1'b0));
    step();
    check("rs_held", obs(), ex(IDLE_W, IDLE_K, 1'b0, 1'b0));
`ifdef PHY_TX_STAT_EN
    check("rs_cnts", 64'({frame_cnt, underrun_cnt}), 64'd0);
`endif
    drive(1'b0, 32'h0, 1'b0, 4'hF);
    rst = 1'b0;
    idle_run = 99;
    mon_on = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 5);
      dly = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: kp = 4'b1111;
        1: kp = 4'b1110;
        2: kp = 4'b1100;
        default: kp = 4'b1000;
      endcase
      for (int b = 0; b < len; b++) dd[b] = $urandom();
      exp_q.push_back({SOF_W, SOF_K});
      for (int b = 0; b < len - 1; b++) exp_q.push_back({dd[b], 4'b0000});
      push_term(dd[len-1], kp);
      for (int b = 0; b < len; b++) begin
        send_beat(dd[b], b == len - 1, (b == len - 1) ? kp : 4'hF, ok);
        if (!ok) check("rand_handshake", 64'(ok), 64'd1);
      end
      drive(1'b0, 32'h0, 1'b0, 4'hF);
      repeat (dly) step();
    end
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) step();
    repeat (4) step();
    mon_on = 1'b0;
    check("rand_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
